// File: rtl/mult_share_arbiter_if.sv
// rtl/mult_share_arbiter_if.sv - requester/multiplier bus bundle for mult_share_arbiter
interface mult_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTHA  = 20,
  parameter int WIDTHB  = 20,
  parameter int WIDTHP  = 40
) ();
  logic [NUM_REQ-1:0]        Req;
  logic [NUM_REQ*WIDTHA-1:0] DataA;
  logic [NUM_REQ*WIDTHB-1:0] DataB;
  logic [NUM_REQ-1:0]        Ack;
  logic [WIDTHA-1:0]         MultA;
  logic [WIDTHB-1:0]         MultB;
  logic [WIDTHP-1:0]         MultResult;
  logic [WIDTHP-1:0]         Result;
  logic [NUM_REQ-1:0]        ResultValid;
  logic                      Busy;

  // arbiter side
  modport slave (
    input  Req, DataA, DataB, MultResult,
    output Ack, MultA, MultB, Result, ResultValid, Busy
  );

  // requesters plus the multiplier instance
  modport master (
    output Req, DataA, DataB, MultResult,
    input  Ack, MultA, MultB, Result, ResultValid, Busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - shares one pipelined signed multiplier among NUM_REQ requesters (option: MULT_SHARE_ARB_FIXED_PRIO_EN)
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTHA  = 20,
  parameter int WIDTHB  = 20,
  parameter int WIDTHP  = 40,
  parameter int PIPE    = 1
) (
  input logic Clock,
  input logic Sclr_n,
  mult_share_arbiter_if.slave bus
);
  localparam int IDXW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = PIPE + 1;

  logic              gnt_valid;
  logic [IDXW-1:0]   gnt_idx;
  logic [IDXW-1:0]   cand;
  logic [WIDTHA-1:0] mult_a;
  logic [WIDTHB-1:0] mult_b;
  logic [WIDTHP-1:0] result;
  logic [NUM_REQ-1:0] result_valid;
  // tag pipe mirrors the multiplier latency plus the operand register
  logic [DEPTH-1:0]  tag_valid;
  logic [IDXW-1:0]   tag_idx [DEPTH];

`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
  // fixed priority: scan downward so the lowest requesting index is the last writer
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (Sclr_n) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        cand = IDXW'(i);
        if (bus.Req[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end
`else
  logic [IDXW-1:0] ptr;

  // round-robin: scan farthest offset first so the nearest index after ptr wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (Sclr_n) begin
      for (int off = NUM_REQ; off >= 1; off--) begin
        cand = IDXW'((int'(ptr) + off) % NUM_REQ);
        if (bus.Req[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  // pointer follows the last grant; reset value gives requester 0 first priority
  always_ff @(posedge Clock) begin
    if (!Sclr_n)        ptr <= IDXW'(NUM_REQ - 1);
    else if (gnt_valid) ptr <= gnt_idx;
  end
`endif

  assign bus.Ack = gnt_valid ? (NUM_REQ'(1) << gnt_idx) : '0;

  // operand register feeding the multiplier; holds when nothing is granted
  always_ff @(posedge Clock) begin
    if (!Sclr_n) begin
      mult_a <= '0;
      mult_b <= '0;
    end else if (gnt_valid) begin
      mult_a <= bus.DataA[int'(gnt_idx)*WIDTHA +: WIDTHA];
      mult_b <= bus.DataB[int'(gnt_idx)*WIDTHB +: WIDTHB];
    end
  end

  // issuer tags shift every cycle; no stall, reset discards everything in flight
  always_ff @(posedge Clock) begin
    if (!Sclr_n) begin
      tag_valid <= '0;
      for (int k = 0; k < DEPTH; k++) tag_idx[k] <= '0;
    end else begin
      tag_valid[0] <= gnt_valid;
      tag_idx[0]   <= gnt_idx;
      for (int k = 1; k < DEPTH; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_idx[k]   <= tag_idx[k-1];
      end
    end
  end

  // capture the product only when the tail tag is live; stale MultResult is ignored
  always_ff @(posedge Clock) begin
    if (!Sclr_n) begin
      result       <= '0;
      result_valid <= '0;
    end else begin
      result_valid <= '0;
      if (tag_valid[PIPE]) begin
        result       <= bus.MultResult;
        result_valid <= NUM_REQ'(1) << tag_idx[PIPE];
      end
    end
  end

  assign bus.MultA       = mult_a;
  assign bus.MultB       = mult_b;
  assign bus.Result      = result;
  assign bus.ResultValid = result_valid;
  assign bus.Busy        = (|tag_valid) | (|result_valid);
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one pipelined signed 20x20->40 multiplier (LPM_MULT black box, pipeline depth PIPE) among NUM_REQ requesters.
- Each cycle it grants at most one request, drives the granted operands to the multiplier, and tracks the issuer through the pipeline.
- It returns each product to the issuing requester with a one-hot valid.
- Sits between the datapath channels and the single multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTHA, 20, operand A width.
- WIDTHB, 20, operand B width.
- WIDTHP, 40, product width (WIDTHA+WIDTHB).
- PIPE, 1, register stages inside the external multiplier (0..4).

Ports:
- Clock  in  1  rising-edge clock.
- Sclr_n  in  1  synchronous active-low reset.
- Req  in  NUM_REQ  per-requester request, level.
- DataA  in  NUM_REQ*WIDTHA  packed A operands; requester i at [i*WIDTHA +: WIDTHA].
- DataB  in  NUM_REQ*WIDTHB  packed B operands; requester i at [i*WIDTHB +: WIDTHB].
- Ack  out  NUM_REQ  one-hot grant, combinational, same cycle as Req.
- MultA  out  WIDTHA  registered operand to multiplier DataA.
- MultB  out  WIDTHB  registered operand to multiplier DataB.
- MultResult  in  WIDTHP  multiplier Result.
- Result  out  WIDTHP  registered product (signed).
- ResultValid  out  NUM_REQ  one-hot, Result belongs to requester i.
- Busy  out  1  high while any product is in flight.

Behaviour:
- Clock is Clock. Reset is Sclr_n: synchronous, active-low.
- Reset values:
  - MultA=0, MultB=0, Result=0, ResultValid=0, Busy=0.
  - Tag pipe cleared.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- Arbitration, cycle t:
  - If Sclr_n=1 and Req!=0, Ack is one-hot on the first set Req bit, searching upward from pointer+1 with wrap-around.
  - The pointer updates to the granted index at the edge.
  - Ack=0 when Req=0 or Sclr_n=0.
- Requester contract: hold Req and operands stable until Ack. Deassert Req the cycle after Ack unless issuing another operation; back-to-back ops are allowed.
- Issue: at the edge ending cycle t, the granted operands load into MultA/MultB. If nothing is granted, MultA/MultB hold their values.
- Tag pipe: depth PIPE+1. Each entry holds {valid, index}, loaded from the grant, shifted every cycle, no stall.
- Latency: Ack in cycle t -> Result/ResultValid in cycle t+2+PIPE, i.e. t+3 at default. ResultValid is high for exactly one cycle per grant.
- Result: registers MultResult when the tail tag is valid; otherwise holds its value.
- Throughput: one grant per cycle sustained. With all Req high, grants rotate 0,1,2,3,0...
- Busy = OR of all tag valid bits plus the ResultValid register.
- Arithmetic: the multiplier computes signed two's complement. No rounding or saturation here. -2^19 * -2^19 = 2^38, which fits in 40 bits.
- Reset mid-operation: all in-flight tags are discarded and no ResultValid follows. The multiplier itself is not cleared, and stale MultResult is ignored because its tags are invalid.
- Simultaneous events: a new grant and a result return in the same cycle are independent. Req arriving with Sclr_n=0 is not acked.
- PIPE=0 (combinational multiplier) is legal: latency t+2.

Optional Feature:
- Macro: MULT_SHARE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The pointer is not implemented, and requester 0 can starve the others.
- Undefined (default): round-robin as above.
- Latency and all other behaviour are identical in both builds.

Test Plan:
- Setup for all scenarios: bench behavioural signed multiplier model with PIPE=1, output registered.
- Single request: Req=0001, A0=3, B0=-5 at cycle 0 -> Ack=0001 in cycle 0; cycle 3: ResultValid=0001, Result=40'hFF_FFFF_FFF1 (-15); other cycles ResultValid=0.
- Full contention: Req=1111 held for 8 cycles, Ai=i+1, Bi=10 -> Ack sequence 0001,0010,0100,1000 repeated. Results 10,20,30,40 arrive from cycle 3 onward with matching ResultValid.
- Extremes: A=20'h80000, B=20'h80000 -> Result=40'h40_0000_0000. A=20'h7FFFF, B=20'h80000 -> Result=40'hC0_0008_0000.
- Reset mid-flight: grants in cycles 0 and 1; Sclr_n=0 in cycle 2 -> no ResultValid in cycles 3-5; Busy=0 after the reset edge; next grant goes to requester 0.
- Fixed-priority build (macro defined): Req=1111 held 4 cycles -> Ack=0001 every cycle. Undefined build with the same stimulus -> rotation.
- Idle/hold: Req=0 for 5 cycles after a result -> Ack=0, MultA/MultB and Result unchanged, Busy=0.
